uart_tx_arb: RTL

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: four-way round-robin arbiter feeding a single uart_tx_byte.
// Each grant may send up to MAX_BURST bytes back to back. tx_send/ack are
// decoded from the LOAD state, and tx_data is captured on the edge that
// enters LOAD, so the byte is stable for the whole strobe cycle and stays
// held until the transmitter drops busy.
//
// Timing relative to the send strobe (cycle 0 = the LOAD cycle):
//   - request rise -> tx_send : 2 cycles (request must be seen on two
//     consecutive edges before it can win arbitration)
//   - tx_busy fall -> tx_send : 1 cycle within a burst
//   - timeout_err rises in cycle BUSY_WAIT if tx_busy never rose
//     (exact for BUSY_WAIT >= 2)
module uart_tx_arb #(
    parameter int MAX_BURST = 16,
    parameter int BUSY_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  grant,
    output logic [3:0]  ack,
    output logic        tx_block,
    output logic        tx_send,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [7:0]  BURST_MAX = 8'(MAX_BURST);
    // WAIT_BUSY cycle j holds wait_q = j-1; the flag is raised at the end of
    // cycle BUSY_WAIT-1 so that it is visible in cycle BUSY_WAIT.
    localparam logic [15:0] WAIT_LIM  = (BUSY_WAIT > 2) ? 16'(BUSY_WAIT - 2) : 16'd0;

    state_t      state_q, state_d;
    logic [3:0]  grant_q, grant_d;
    logic [1:0]  gidx_q, gidx_d;
    logic [1:0]  last_q, last_d;
    logic [7:0]  count_q, count_d;
    logic [15:0] wait_q, wait_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        timeout_q, timeout_d;
    logic [3:0]  req_q, req_d;

    logic [3:0]  elig;
    logic        found;
    logic [1:0]  pick;

    // Byte lane of one requester inside the packed request data.
    function automatic logic [7:0] byte_of(input logic [31:0] d, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        return b;
    endfunction

    // Round-robin pick: first eligible requester after the last owner.
    always_comb begin
        elig  = req & req_q;
        found = 1'b0;
        pick  = last_q;
        for (int i = 1; i <= 4; i++) begin
            if (!found && elig[last_q + 2'(i)]) begin
                found = 1'b1;
                pick  = last_q + 2'(i);
            end
        end
    end

    // Next-state and strobe decode for the send sequencer.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        last_d    = last_q;
        count_d   = count_q;
        wait_d    = wait_q;
        tx_data_d = tx_data_q;
        timeout_d = timeout_q;
        req_d     = req;
        tx_send   = 1'b0;
        ack       = 4'b0000;

        case (state_q)
            IDLE: begin
                if (enable && !tx_busy && found) begin
                    grant_d   = 4'b0001 << pick;
                    gidx_d    = pick;
                    tx_data_d = byte_of(req_data, pick);
                    state_d   = LOAD;
                end
            end

            LOAD: begin
                tx_send = 1'b1;
                ack     = grant_q;
                if (count_q < BURST_MAX) begin
                    count_d = count_q + 8'd1;
                end
                wait_d  = 16'd0;
                state_d = WAIT_BUSY;
            end

            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (wait_q >= WAIT_LIM) begin
                    timeout_d = 1'b1;
                    state_d   = WAIT_DONE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end

            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (req[gidx_q] && enable && (count_q < BURST_MAX)) begin
                        tx_data_d = byte_of(req_data, gidx_q);
                        state_d   = LOAD;
                    end else begin
                        grant_d = 4'b0000;
                        last_d  = gidx_q;
                        count_d = 8'd0;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset puts requester 0 first in line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            grant_q   <= 4'b0000;
            gidx_q    <= 2'd0;
            last_q    <= 2'd3;
            count_q   <= 8'd0;
            wait_q    <= 16'd0;
            tx_data_q <= 8'h00;
            timeout_q <= 1'b0;
            req_q     <= 4'b0000;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            last_q    <= last_d;
            count_q   <= count_d;
            wait_q    <= wait_d;
            tx_data_q <= tx_data_d;
            timeout_q <= timeout_d;
            req_q     <= req_d;
        end
    end

    // Block the transmitter only while parked and disabled (or held in reset).
    always_comb begin
        tx_block = (state_q == IDLE) && (!enable || !rst);
    end

    assign grant       = grant_q;
    assign tx_data     = tx_data_q;
    assign timeout_err = timeout_q;

endmodule
